// File: rtl/mem_word_master_if.sv
// +----------------------------------------------------------------------+
// | system_widths_pkg / cache_mem_if                                     |
// | System address width and the byte-wide cache memory handshake bus.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package system_widths_pkg;
  localparam int ADDR_W = 11;
endpackage

interface cache_mem_if;
  import system_widths_pkg::*;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [7:0]        mem_req_write;
  logic              mem_resp_valid;
  logic [7:0]        mem_resp_data;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_write,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_write,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

`default_nettype wire

// File: rtl/mem_word_master.sv
// +----------------------------------------------------------------------+
// | mem_word_master                                                      |
// | Splits each CPU word access into sequential byte memory transactions.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_word_master
  import system_widths_pkg::*;
#(
  parameter  int WORD_BYTES = 2,
  localparam int DATA_W     = 8 * WORD_BYTES
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_resp_valid,
  output logic [DATA_W-1:0] cpu_resp_rdata,
  cache_mem_if.master       mem_if
);

  localparam int                 c_IDX_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(WORD_BYTES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rbuf;
  logic [DATA_W-1:0]   r_rdata;
  logic [c_IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0]   w_rbuf_nxt;
  logic                w_byte_done;

  assign w_byte_done = (r_state == WAIT) && mem_if.mem_resp_valid;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (cpu_req_valid)            w_state_nxt = REQ;
      REQ:  if (mem_if.mem_req_ready)     w_state_nxt = WAIT;
      WAIT: if (mem_if.mem_resp_valid)    w_state_nxt = (r_idx == c_LAST_IDX) ? DONE : REQ;
      DONE:                               w_state_nxt = IDLE;
      default:                            w_state_nxt = IDLE;
    endcase
  end

  // Load buffer with the current response byte merged into lane r_idx
  always_comb begin
    w_rbuf_nxt = r_rbuf;
    w_rbuf_nxt[{r_idx, 3'b000} +: 8] = mem_if.mem_resp_data;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rbuf  <= '0;
      r_rdata <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && cpu_req_valid) begin
        r_we    <= cpu_req_we;
        r_addr  <= cpu_req_addr;
        r_wdata <= cpu_req_we ? cpu_req_wdata : '0;
        r_rbuf  <= '0;
        r_idx   <= '0;
      end else if (w_byte_done) begin
        if (!r_we) r_rbuf <= w_rbuf_nxt;
        if (r_idx == c_LAST_IDX) begin
          r_rdata <= r_we ? '0 : w_rbuf_nxt;
        end else begin
          // Store data shifts down so the next byte always sits in the low lane
          r_wdata <= r_wdata >> 8;
          r_addr  <= r_addr + 1'b1;
          r_idx   <= r_idx + 1'b1;
        end
      end
    end
  end

  assign cpu_req_ready        = (r_state == IDLE);
  assign cpu_resp_valid       = (r_state == DONE);
  assign cpu_resp_rdata       = r_rdata;
  assign mem_if.mem_req_valid = (r_state == REQ);
  assign mem_if.mem_req_we    = r_we;
  assign mem_if.mem_req_addr  = r_addr;
  assign mem_if.mem_req_write = r_wdata[7:0];

endmodule

`default_nettype wire

// File: doc/mem_word_master.md
MEM_WORD_MASTER -- requirements
Module: mem_word_master

Interface
REQ-001 Parameter WORD_BYTES, default 2, SHALL set the number of bytes per CPU access; legal range 1..4.
REQ-002 Derived DATA_W = 8*WORD_BYTES SHALL be the CPU data width; ADDR_W SHALL come from system_widths_pkg.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 resetN  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 cpu_req_valid  input  1  SHALL mark a valid CPU access request.
REQ-006 cpu_req_ready  output  1  SHALL indicate the block can accept a CPU request.
REQ-007 cpu_req_we  input  1  SHALL select store (1) or load (0).
REQ-008 cpu_req_addr  input  ADDR_W  SHALL give the byte address of the lowest byte.
REQ-009 cpu_req_wdata  input  DATA_W  SHALL give store data, little-endian.
REQ-010 cpu_resp_valid  output  1  SHALL be a one-cycle completion pulse.
REQ-011 cpu_resp_rdata  output  DATA_W  SHALL hold assembled load data.
REQ-012 mem_if  cache_mem_if.master  SHALL drive mem_req_valid, mem_req_we, mem_req_addr[ADDR_W], mem_req_write[8] and receive mem_req_ready, mem_resp_valid, mem_resp_data[8].

Function
REQ-013 The block SHALL split each CPU access into WORD_BYTES sequential byte transactions on mem_if, byte i at address (cpu_req_addr + i) mod 2^ADDR_W.
REQ-014 Byte i SHALL map to data bits [8i+7:8i] (little-endian) for both loads and stores.
REQ-015 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-016 IDLE: cpu_req_ready=1; on cpu_req_valid SHALL latch we/addr/wdata, clear byte index and load buffer, go REQ.
REQ-017 REQ: mem_req_valid=1 with mem_req_addr, mem_req_we and mem_req_write (store byte i, else 0) held stable; on mem_req_ready SHALL go WAIT.
REQ-018 WAIT: mem_req_valid=0; on mem_resp_valid SHALL capture mem_resp_data into byte i for loads (discard for stores); if i==WORD_BYTES-1 go DONE, else i+1 and go REQ.
REQ-019 DONE: cpu_resp_valid=1 for exactly one cycle, cpu_resp_rdata = assembled data for loads, 0 for stores; go IDLE.
REQ-020 cpu_req_ready SHALL be 0 in REQ, WAIT and DONE; exactly one CPU access and at most one byte transaction SHALL be outstanding.
REQ-021 mem_resp_valid outside WAIT SHALL be ignored with no state change.
REQ-022 mem_req_ready low in REQ SHALL stall with request fields unchanged, indefinitely.
REQ-023 Against a memory with mem_req_ready=1 and 1-cycle registered response, latency SHALL be 2*WORD_BYTES+1 cycles from the accepting edge to cpu_resp_valid high (5 cycles for WORD_BYTES=2).
REQ-024 Address increment SHALL wrap modulo 2^ADDR_W with no error indication.
REQ-025 cpu_resp_rdata SHALL hold its value after DONE until the next completion.
REQ-026 All outputs SHALL be registered or decoded from the state register only; no combinational path from cpu_req_* to mem_if.

Reset
REQ-027 While resetN=0, state SHALL be IDLE, byte index 0, load buffer 0.
REQ-028 Reset values: cpu_req_ready=1, cpu_resp_valid=0, cpu_resp_rdata=0, mem_req_valid=0, mem_req_we=0, mem_req_addr=0, mem_req_write=0.
REQ-029 Reset asserted mid-access SHALL abort the access immediately; no cpu_resp_valid SHALL be issued for it, and a memory response arriving after reset release SHALL be ignored (REQ-021).

Verification
REQ-030 Store addr 0x010 wdata 0xBEEF, then load 0x010 -> mem writes 0xEF@0x010, 0xBE@0x011; load returns cpu_resp_rdata=0xBEEF.
REQ-031 Load at 0x7FF (ADDR_W=11) after storing 0x12@0x7FF, 0x34@0x000 -> byte requests to 0x7FF then 0x000; rdata=0x3412.
REQ-032 Always-ready memory, accept at cycle 0 -> cpu_resp_valid high only in cycle 5, cpu_req_ready low in cycles 1-5.
REQ-033 Hold mem_req_ready=0 for 3 cycles in REQ -> mem_req_valid/addr stable throughout; latency grows by 3.
REQ-034 Assert resetN=0 during WAIT of byte 0 -> all outputs at reset values; after release cpu_req_ready=1, no cpu_resp_valid.
REQ-035 Inject mem_resp_valid=1, data 0xAA while IDLE -> no state change, cpu_resp_valid stays 0.
